// File: rtl/wb_arb_pkg.sv
// Shared types for the two-requester Wishbone memory arbiter: FSM state encoding and one-hot grant constants.
// State values double as the grant vector so grant_o can be taken straight from the state register.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating granted-cycle counter; expired is combinational in the cycle the count reaches TIMEOUT_CYCLES.
// No backpressure: clear has priority over enable; TIMEOUT_CYCLES = 0 never expires.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds completed granted cycles, so the current cycle is the TIMEOUT_CYCLES-th when cnt == LAST
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == CNT_LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory between instruction fetch (m0) and data (m1) requesters.
// One cycle from request to s_cyc_o, one IDLE bubble between transactions; requester waits on ack/err.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i,

  output logic [1:0]              grant_o
);

  arb_state_e state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       m0_vld, m1_vld;
  logic       leave_gnt;
  logic       tmo_enable, tmo_clear, tmo_expired;

  assign m0_vld = m0_cyc_i & m0_stb_i;
  assign m1_vld = m1_cyc_i & m1_stb_i;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Counting only runs while the granted requester holds cyc and no ack arrives, so ack beats a same-cycle timeout
  always_comb begin
    tmo_enable = 1'b0;
    unique case (state)
      GNT0:    tmo_enable = m0_cyc_i & ~s_ack_i;
      GNT1:    tmo_enable = m1_cyc_i & ~s_ack_i;
      default: tmo_enable = 1'b0;
    endcase
  end

  assign tmo_clear = (state == IDLE) | leave_gnt;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    leave_gnt      = 1'b0;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_wstrb_o      = '0;
    s_addr_o       = '0;
    s_data_o       = '0;
    m0_ack_o       = 1'b0;
    m0_err_o       = 1'b0;
    m1_ack_o       = 1'b0;
    m1_err_o       = 1'b0;
    grant_o        = GRANT_NONE;

    unique case (state)
      IDLE: begin
        if (m0_vld && m1_vld) begin
          state_nxt = last_grant ? GNT0 : GNT1;
        end else if (m0_vld) begin
          state_nxt = GNT0;
        end else if (m1_vld) begin
          state_nxt = GNT1;
        end
      end

      GNT0: begin
        grant_o   = GRANT_M0;
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_wstrb_o = m0_wstrb_i;
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        // An aborting requester gets neither ack nor err even if memory answers
        if (!m0_cyc_i) begin
          leave_gnt = 1'b1;
        end else if (s_ack_i) begin
          m0_ack_o  = 1'b1;
          leave_gnt = 1'b1;
        end else if (tmo_expired) begin
          m0_err_o  = 1'b1;
          leave_gnt = 1'b1;
        end
        if (leave_gnt) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end

      GNT1: begin
        grant_o   = GRANT_M1;
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_wstrb_o = m1_wstrb_i;
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        if (!m1_cyc_i) begin
          leave_gnt = 1'b1;
        end else if (s_ack_i) begin
          m1_ack_o  = 1'b1;
          leave_gnt = 1'b1;
        end else if (tmo_expired) begin
          m1_err_o  = 1'b1;
          leave_gnt = 1'b1;
        end
        if (leave_gnt) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
